// File: rtl/os_core_sequencer.sv
// Output-stationary instruction sequencer: produces the registered core.inst word for one tile per start.
// Define SEQ_PMEM_WB_EN to add the WB state that copies OFIFO rows into psum SRAM.
module os_core_sequencer #(
    parameter int ROW        = 8,
    parameter int COL        = 8,
    parameter int LEN_KIJ    = 9,
    parameter int CHUNK      = 8,
    parameter int ACT_BASE   = 0,
    parameter int WGT_BASE   = 576,
    parameter int PMEM_BASE  = 0,
    parameter int DRAIN_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [63:0] inst,
    output logic        busy,
    output logic        done
);

    localparam int K       = LEN_KIJ * ROW;
    localparam int NCH     = K / CHUNK;
    localparam int MAX_AB  = (CHUNK > ROW) ? CHUNK : ROW;
    localparam int CNT_MAX = (DRAIN_WAIT > MAX_AB) ? DRAIN_WAIT : MAX_AB;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int NW      = $clog2(NCH + 1);

    localparam logic [CW-1:0] BEAT_LAST  = CW'(CHUNK);
    localparam logic [CW-1:0] ACC_LAST   = CW'(CHUNK - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(DRAIN_WAIT - 1);
    localparam logic [CW-1:0] PASS_LAST  = CW'(ROW - 1);
    localparam logic [NW-1:0] CHUNK_LAST = NW'(NCH - 1);

    localparam logic [10:0] ACT_A   = 11'(ACT_BASE);
    localparam logic [10:0] WGT_A   = 11'(WGT_BASE);
    localparam logic [10:0] CHUNK_A = 11'(CHUNK);

    localparam logic [63:0] IDLE_WORD = 64'h0000_0011_800C_0000;

    localparam int unused_col = COL;

    typedef enum logic [2:0] {
        IDLE,
        LD_ACT,
        LD_WGT,
        ACC,
        WAIT,
        PASS,
`ifdef SEQ_PMEM_WB_EN
        WB,
`endif
        FIN
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] beat, beat_n;
    logic [NW-1:0] chunk, chunk_n;
    logic [63:0]   inst_n;

`ifdef SEQ_PMEM_WB_EN
    localparam int            RW        = $clog2(ROW + 1);
    localparam logic [RW-1:0] ROW_R     = RW'(ROW);
    localparam logic [10:0]   PMEM_A    = 11'(PMEM_BASE);

    logic [RW-1:0] rd_cnt, rd_cnt_n;
    logic [RW-1:0] wr_cnt, wr_cnt_n;
    logic          rd_n, wr_n;
    logic [10:0]   wr_addr;
`else
    localparam int unused_pmem_base = PMEM_BASE;
    logic unused_ofifo_valid;
    assign unused_ofifo_valid = ofifo_valid;
`endif

    // Next-state and next-word logic; the word is then registered so inst has no input-to-output path.
    always_comb begin
        state_n = state;
        beat_n  = beat;
        chunk_n = chunk;
`ifdef SEQ_PMEM_WB_EN
        rd_cnt_n = rd_cnt;
        wr_cnt_n = wr_cnt;
        rd_n     = 1'b0;
        wr_n     = 1'b0;
        wr_addr  = '0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LD_ACT;
                    beat_n  = '0;
                    chunk_n = '0;
                end
            end
            LD_ACT, LD_WGT: begin
                if (beat == BEAT_LAST) begin
                    state_n = (state == LD_ACT) ? LD_WGT : ACC;
                    beat_n  = '0;
                end else begin
                    beat_n = beat + CW'(1);
                end
            end
            ACC: begin
                if (beat == ACC_LAST) begin
                    beat_n = '0;
                    if (chunk == CHUNK_LAST) begin
                        state_n = WAIT;
                    end else begin
                        state_n = LD_ACT;
                        chunk_n = chunk + NW'(1);
                    end
                end else begin
                    beat_n = beat + CW'(1);
                end
            end
            WAIT: begin
                if (beat == WAIT_LAST) begin
                    state_n = PASS;
                    beat_n  = '0;
                end else begin
                    beat_n = beat + CW'(1);
                end
            end
            PASS: begin
                if (beat == PASS_LAST) begin
                    beat_n = '0;
`ifdef SEQ_PMEM_WB_EN
                    state_n  = WB;
                    rd_cnt_n = '0;
                    wr_cnt_n = '0;
`else
                    state_n = FIN;
`endif
                end else begin
                    beat_n = beat + CW'(1);
                end
            end
`ifdef SEQ_PMEM_WB_EN
            WB: begin
                if (rd_cnt == ROW_R && !inst[6]) begin
                    state_n = FIN;
                end
            end
`endif
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

`ifdef SEQ_PMEM_WB_EN
        // A row read in the current word is written to pmem in the next word, independent of ofifo_valid.
        if (state_n == WB) begin
            wr_n    = inst[6];
            wr_addr = PMEM_A + 11'(wr_cnt_n);
            rd_n    = ofifo_valid && (rd_cnt_n < ROW_R);
            if (wr_n) wr_cnt_n = wr_cnt_n + RW'(1);
            if (rd_n) rd_cnt_n = rd_cnt_n + RW'(1);
        end
`endif

        inst_n = IDLE_WORD;
        case (state_n)
            LD_ACT, LD_WGT: begin
                if (beat_n != BEAT_LAST) begin
                    inst_n[19]   = 1'b0;
                    inst_n[17:7] = ((state_n == LD_ACT) ? ACT_A : WGT_A)
                                   + 11'(chunk_n) * CHUNK_A + 11'(beat_n);
                end
                // Beat i stores the xmem data addressed at beat i-1.
                if (beat_n != '0) begin
                    if (state_n == LD_ACT) inst_n[2] = 1'b1;
                    else                   inst_n[37] = 1'b1;
                end
            end
            ACC: begin
                inst_n[4] = 1'b1;
                inst_n[3] = 1'b1;
                inst_n[0] = 1'b1;
            end
            PASS: inst_n[1] = 1'b1;
`ifdef SEQ_PMEM_WB_EN
            WB: begin
                inst_n[6] = rd_n;
                if (wr_n) begin
                    inst_n[32]    = 1'b0;
                    inst_n[31]    = 1'b0;
                    inst_n[30:20] = wr_addr;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            beat  <= '0;
            chunk <= '0;
            inst  <= IDLE_WORD;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SEQ_PMEM_WB_EN
            rd_cnt <= '0;
            wr_cnt <= '0;
`endif
        end else begin
            state <= state_n;
            beat  <= beat_n;
            chunk <= chunk_n;
            inst  <= inst_n;
            busy  <= (state_n != IDLE);
            done  <= (state_n == FIN);
`ifdef SEQ_PMEM_WB_EN
            rd_cnt <= rd_cnt_n;
            wr_cnt <= wr_cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_os_core_sequencer.sv
// Self-checking bench for os_core_sequencer: vector table for reset/start corners, then full tiles
// checked word-by-word against a trace built from the sequencing rules, plus aggregate counts.
`timescale 1ns/1ps
module tb_os_core_sequencer;

    localparam logic [63:0] IDLE_W = 64'h0000_0011_800C_0000;
`ifdef SEQ_PMEM_WB_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif
    localparam int MAXC = 700;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        ofifo_valid = 1'b0;
    logic [63:0] inst;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    os_core_sequencer #(
        .ROW(8), .COL(8), .LEN_KIJ(9), .CHUNK(8),
        .ACT_BASE(0), .WGT_BASE(576), .PMEM_BASE(0), .DRAIN_WAIT(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        st;
        logic [63:0] w;
        logic        bz;
        logic        dn;
    } vec_t;

    vec_t        tbl[$];
    logic [63:0] exp_q[$];
    bit          vpat[MAXC];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [63:0] mk(input bit xrd, input int xa, input bit l0w, input bit l1w,
                                       input bit accum, input bit pas, input bit ord,
                                       input bit pwr, input int pa);
        logic [63:0] w;
        w = IDLE_W;
        if (xrd) begin
            w[19]   = 1'b0;
            w[17:7] = xa[10:0];
        end
        w[2]  = l0w;
        w[37] = l1w;
        if (accum) begin
            w[0] = 1'b1;
            w[3] = 1'b1;
            w[4] = 1'b1;
        end
        w[1] = pas;
        w[6] = ord;
        if (pwr) begin
            w[32]    = 1'b0;
            w[31]    = 1'b0;
            w[30:20] = pa[10:0];
        end
        return w;
    endfunction

    // Expected word for every cycle of one tile, from the first active word through FIN.
    function automatic void build_trace();
        int  reads, writes, k;
        bit  pend, rd;
        exp_q.delete();
        for (int c = 0; c < 9; c++) begin
            for (int i = 0; i <= 8; i++) exp_q.push_back(mk(i < 8, c*8 + i, i >= 1, 0, 0, 0, 0, 0, 0));
            for (int i = 0; i <= 8; i++) exp_q.push_back(mk(i < 8, 576 + c*8 + i, 0, i >= 1, 0, 0, 0, 0, 0));
            for (int i = 0; i < 8; i++) exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
        end
        for (int i = 0; i < 16; i++) exp_q.push_back(IDLE_W);
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        if (WB_EN) begin
            reads = 0;
            writes = 0;
            pend = 1'b0;
            while (reads < 8 || pend) begin
                k = exp_q.size();
                rd = (reads < 8) && vpat[k-1];
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, rd, pend, writes));
                if (pend) writes++;
                pend = rd;
                if (rd) reads++;
            end
        end
        exp_q.push_back(IDLE_W);
    endfunction

    function automatic int exp_done_idx();
        int ones, st;
        ones = 0;
        st = 0;
        if (!WB_EN) return 258;
        for (int k = 257; k < MAXC && ones < 8; k++) begin
            if (vpat[k]) ones++;
            else st++;
        end
        return 267 + st;
    endfunction

    task automatic run_tile(input int mode, input bit rnd_start, input int reset_at, input bit fin_start);
        int len, done_at, n_l0, n_l1, n_acc, n_pass, n_ord, n_pw, n_rd, want_a, rd_base;
        bit prev_cen;
        for (int k = 0; k < MAXC; k++) begin
            case (mode)
                0:       vpat[k] = 1'b1;
                1:       vpat[k] = (k < 257) ? 1'b0 : (k < 267) ? 1'b0 : ((k - 267) % 2 == 0);
                default: vpat[k] = (k >= 400) || ($urandom_range(0, 3) != 0);
            endcase
        end
        build_trace();
        len = exp_q.size();
        done_at = -1;
        n_l0 = 0; n_l1 = 0; n_acc = 0; n_pass = 0; n_ord = 0; n_pw = 0; n_rd = 0;
        prev_cen = 1'b1;

        start = 1'b1;
        ofifo_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;

        for (int k = 0; k < len; k++) begin
            chk($sformatf("inst[%0d]", k), inst, exp_q[k]);
            chk($sformatf("busy[%0d]", k), 64'(busy), 64'(1));
            chk($sformatf("done[%0d]", k), 64'(done), 64'(k == len - 1));
            if (done && done_at < 0) done_at = k;
            if (inst[2])  n_l0++;
            if (inst[37]) n_l1++;
            if (inst[0])  n_acc++;
            if (inst[1])  n_pass++;
            if (!inst[19]) begin
                rd_base = (n_rd / 16) * 8;
                want_a = (n_rd % 16 < 8) ? rd_base + n_rd % 16 : 576 + rd_base + n_rd % 16 - 8;
                chk($sformatf("a_xmem[%0d]", n_rd), 64'(inst[17:7]), 64'(want_a));
                if (prev_cen) chk("wr_on_first_read", 64'({inst[37], inst[2]}), 64'(0));
                n_rd++;
            end
            if (inst[2] || inst[37]) chk("wr_after_read", 64'(prev_cen), 64'(0));
            if (!inst[32]) begin
                chk("pmem_wen", 64'(inst[31]), 64'(0));
                chk($sformatf("pmem_addr[%0d]", n_pw), 64'(inst[30:20]), 64'(n_pw));
                n_pw++;
            end
            if (inst[6]) begin
                n_ord++;
                chk("ofifo_rd_valid", 64'((k > 0) ? vpat[k-1] : 1'b0), 64'(1));
            end
            prev_cen = inst[19];

            ofifo_valid = vpat[k];
            start = (k == len - 1) ? fin_start : (rnd_start && ($urandom_range(0, 7) == 0));
            if (k == reset_at) begin
                reset = 1'b0;
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (k == reset_at) begin
                reset = 1'b1;
                ofifo_valid = 1'b0;
                chk("rst_mid_inst", inst, IDLE_W);
                chk("rst_mid_busy", 64'(busy), 64'(0));
                chk("rst_mid_done", 64'(done), 64'(0));
                for (int j = 0; j < 4; j++) begin
                    @(posedge clk); #1;
                    chk("post_rst_done", 64'(done), 64'(0));
                    chk("post_rst_inst", inst, IDLE_W);
                end
                return;
            end
        end
        start = 1'b0;
        ofifo_valid = 1'b0;

        chk("after_fin_inst", inst, IDLE_W);
        chk("after_fin_busy", 64'(busy), 64'(0));
        chk("after_fin_done", 64'(done), 64'(0));
        chk("n_l0_wr", 64'(n_l0), 64'(72));
        chk("n_l1_wr", 64'(n_l1), 64'(72));
        chk("n_acc", 64'(n_acc), 64'(72));
        chk("n_pass", 64'(n_pass), 64'(8));
        chk("n_xmem_rd", 64'(n_rd), 64'(144));
        chk("n_ofifo_rd", 64'(n_ord), 64'(WB_EN ? 8 : 0));
        chk("n_pmem_wr", 64'(n_pw), 64'(WB_EN ? 8 : 0));
        chk("done_cycle", 64'(done_at), 64'(exp_done_idx()));
    endtask

    initial begin
        #20_000_000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int n = 0; n < 5; n++) tbl.push_back('{1'b0, n[0], IDLE_W, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, IDLE_W, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, mk(1, 1, 1, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, mk(1, 2, 1, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, IDLE_W, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, IDLE_W, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, IDLE_W, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, IDLE_W, 1'b0, 1'b0});

        foreach (tbl[n]) begin
            reset = tbl[n].rst;
            start = tbl[n].st;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_inst", n), inst, tbl[n].w);
            chk($sformatf("tbl%0d_busy", n), 64'(busy), 64'(tbl[n].bz));
            chk($sformatf("tbl%0d_done", n), 64'(done), 64'(tbl[n].dn));
        end
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;

        run_tile(0, 1'b0, -1, 1'b1);
        run_tile(1, 1'b1, -1, 1'b0);
        run_tile(0, 1'b0, 125, 1'b0);
        run_tile(2, 1'b1, -1, 1'b1);
        run_tile(2, 1'b1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/os_core_sequencer.md
# os_core_sequencer

Hardware instruction sequencer for the core in output-stationary mode. It generates the core's 64-bit `inst` word each cycle, replacing bench-driven sequencing. On each `start` it runs one full tile: stream activation and weight vectors from xmem into L0/L1 in chunks, issue accumulate steps, drain the array into the OFIFO, and optionally write the OFIFO contents into psum SRAM. It sits between the top-level controller and `core.inst`.

## Interface
- `ROW`, 8: array rows; vectors per drain
- `COL`, 8: array columns
- `LEN_KIJ`, 9: kernel positions; K = LEN_KIJ*ROW = 72 vectors per operand
- `CHUNK`, 8: vectors per load/accumulate burst; K must be divisible by CHUNK
- `ACT_BASE`, 0: xmem address of the first activation vector
- `WGT_BASE`, 576: xmem address of the first weight vector
- `PMEM_BASE`, 0: psum SRAM address of the first written row
- `DRAIN_WAIT`, 16: idle cycles after the last accumulate before drain
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle request to run a tile; sampled only in IDLE
- `ofifo_valid`  in  1  core OFIFO holds a full row
- `inst`  out  64  core instruction word
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at the end of a run

## Operation
- `inst` bit map:
  - [63] debug=0, [37] l1_wr, [36] output_stationary (constant 1), [35] REN_pmem=0, [34] sfu_passthrough=0, [33] acc=0
  - [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5] ififo_wr=0, [4] l1_rd (L1 read strobe), [3] l0_rd, [2] l0_wr, [1] pass_psum, [0] accumulate
- Idle word is 64'h0000_0011_800C_0000: both CEN and WEN high, output_stationary high, everything else 0.
- All `inst` bits are registered. No combinational path from `start` or `ofifo_valid` to `inst`.
- Counters: chunk index c (0..K/CHUNK-1), beat index i (0..CHUNK), row index r.
- FSM states:
  - IDLE: on `start`, set c=0 and go to LD_ACT.
  - LD_ACT, beats i=0..CHUNK:
    - For i<CHUNK: CEN_xmem=0, WEN_xmem=1, A_xmem=ACT_BASE+c*CHUNK+i.
    - For i≥1: l0_wr=1. The 1-cycle SRAM read latency means beat i writes data read at beat i-1.
    - After beat CHUNK, go to LD_WGT.
  - LD_WGT: same as LD_ACT with base WGT_BASE and l1_wr in place of l0_wr. Then go to ACC.
  - ACC: CHUNK cycles of l0_rd=1, l1_rd=1, accumulate=1.
    - If c<K/CHUNK-1: c++ and go to LD_ACT.
    - Otherwise go to WAIT.
  - WAIT: DRAIN_WAIT idle cycles, then go to PASS.
  - PASS: ROW cycles of pass_psum=1. Then go to WB if `SEQ_PMEM_WB_EN` is defined, otherwise to FIN.
  - WB:
    - When ofifo_valid=1 and r<ROW: ofifo_rd=1, r++.
    - One cycle after each ofifo_rd: CEN_pmem=0, WEN_pmem=0, A_pmem=PMEM_BASE+r_written.
    - When ROW rows are written, go to FIN.
    - ofifo_valid low stalls reads but not the pending write.
  - FIN: done=1 for one cycle, then go to IDLE.
- xmem is never written by this block (WEN_xmem=1 always).
- `start` while busy is ignored and is not queued.
- xmem and pmem addresses are 11 bits and wrap mod 2048. No range check.

## Timing
- Reset (`reset`=0 at a `clk` edge):
  - Next cycle: state IDLE, `inst`=idle word, busy=0, done=0, all counters 0.
  - Applies mid-run with no drain and no done pulse.
- The first active `inst` appears in the cycle after `start` is sampled.
- Per chunk: (CHUNK+1)+(CHUNK+1)+CHUNK = 26 cycles at defaults. Nine chunks take 234 cycles.
- After the last chunk: DRAIN_WAIT + ROW = 24 cycles.
- WB: a minimum of ROW+1 = 9 cycles if ofifo_valid is held high.
- Total at defaults with WB and ofifo_valid high: 267 cycles from the first active word to FIN. `done` is asserted in the FIN cycle.
- busy rises the cycle after `start` and falls the cycle after FIN.
- A `start` in the FIN cycle is ignored. A `start` in the cycle after FIN is accepted.

## Configuration
- `SEQ_PMEM_WB_EN` defined:
  - WB state present; rows go to psum SRAM.
  - Total run time = 267 + ofifo stall cycles.
- `SEQ_PMEM_WB_EN` undefined:
  - PASS goes directly to FIN.
  - ofifo_rd, CEN_pmem and WEN_pmem stay at their idle values; the OFIFO is left full for external reads.
  - Run time is 258 cycles.

## Test plan
- Reset behaviour: hold `reset`=0 for 5 cycles while pulsing `start` -> `inst`=64'h0000_0011_800C_0000, busy=0, done=0 throughout.
- Single run with defaults, WB enabled, ofifo_valid=1:
  - A_xmem sequence: 0..7, then 576..583, then 8..15, ...
  - Exactly 72 l0_wr, 72 l1_wr and 72 accumulate cycles.
  - 8 pass_psum cycles, 8 pmem writes at addresses 0..7.
  - done pulses once at cycle 267.
- Latency check: the first l0_wr appears exactly one cycle after the first CEN_xmem=0 in each chunk. There is never an l0_wr in the same cycle as the first read of a chunk.
- ofifo_valid stall: hold low for 10 cycles entering WB, then toggle 1/0 -> ofifo_rd only when valid, pmem writes stay contiguous 0..7, done is delayed by exactly the stall count.
- Mid-run reset: assert `reset`=0 during chunk 4 ACC -> idle word the next cycle, no done. A subsequent `start` restarts at A_xmem=0.
- WB compiled out (`SEQ_PMEM_WB_EN` undefined): CEN_pmem stays 1 and ofifo_rd stays 0 for the entire run; done arrives at cycle 258.
